// File: rtl/save_store.sv
// save_store: streams a contiguous range of one on-chip buffer out to the AXI
// write master. A fixed-latency read pipeline feeds a small skid FIFO whose
// registered head drives m_axis. Reads are credit-limited so the FIFO can
// never overflow under backpressure.
module save_store #(
  parameter int SAVE_INST_BIT_WIDTH = 128,
  parameter int C_M_AXI_ADDR_WIDTH  = 64,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_XFER_SIZE_WIDTH   = 32,
  parameter int C_BUF_RD_LATENCY    = 2,
  parameter int C_FIFO_DEPTH        = 8
) (
  input  logic                           kernel_clk,
  input  logic                           kernel_rst,
  input  logic                           ap_start,
  output logic                           ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  ctrl_addr_offset,
  input  logic [SAVE_INST_BIT_WIDTH-1:0] ctrl_instruction,
  output logic                           save_read_buffer_0_valid,
  output logic [10:0]                    save_read_buffer_0_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_0_data,
  output logic                           save_read_buffer_1_A_valid,
  output logic [10:0]                    save_read_buffer_1_A_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_1_A_data,
  output logic                           save_read_buffer_1_B_valid,
  output logic [10:0]                    save_read_buffer_1_B_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_1_B_data,
  output logic                           save_read_buffer_2_A_valid,
  output logic [10:0]                    save_read_buffer_2_A_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_2_A_data,
  output logic                           save_read_buffer_2_B_valid,
  output logic [10:0]                    save_read_buffer_2_B_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_2_B_data,
  output logic                           wr_ctrl_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  wr_ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]   wr_ctrl_xfer_size_in_bytes,
  input  logic                           wr_ctrl_done,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                           m_axis_tlast
);
  localparam int LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LP_CNT_W    = $clog2(C_FIFO_DEPTH + 1);
  localparam int LP_PTR_W    = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int LP_OCC_W    = LP_CNT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t state, state_next;

  // Latched instruction context and progress counters
  logic [4:0]                  group;
  logic [10:0]                 rd_addr;
  logic [11:0]                 len;
  logic [11:0]                 rd_cnt;
  logic [11:0]                 ret_cnt;
  logic                        done_seen;
  logic [C_BUF_RD_LATENCY-1:0] rd_pipe;

  // Skid FIFO storage; the registered head lives in m_axis_* itself
  logic [C_M_AXI_DATA_WIDTH:0] mem [C_FIFO_DEPTH];
  logic [LP_PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [LP_CNT_W-1:0]         mem_cnt;

  // Instruction decode
  logic [5:0]  inst_group;
  logic [10:0] inst_buf_start;
  logic [11:0] inst_len_raw, inst_len;
  logic [15:0] inst_dram;
  logic        inst_group_ok;
  logic        unused_inst_bits;

  assign inst_group     = ctrl_instruction[5:0];
  assign inst_buf_start = ctrl_instruction[42:32];
  assign inst_len_raw   = ctrl_instruction[59:48];
  assign inst_dram      = ctrl_instruction[79:64];
  assign inst_len       = (inst_len_raw > 12'd2048) ? 12'd2048 : inst_len_raw;
  assign inst_group_ok  = (inst_group == 6'd1) || (inst_group == 6'd2) || (inst_group == 6'd4) ||
                          (inst_group == 6'd8) || (inst_group == 6'd16);
  assign unused_inst_bits = ^{ctrl_instruction[SAVE_INST_BIT_WIDTH-1:80], ctrl_instruction[63:60],
                              ctrl_instruction[47:43], ctrl_instruction[31:6]};

  // Datapath control
  logic                        accept, issue, push, push_last, pop, out_free;
  logic                        load_mem, load_in, mem_push;
  logic [LP_OCC_W-1:0]         occupancy;
  logic [C_M_AXI_DATA_WIDTH-1:0] rd_data;
  logic [C_M_AXI_DATA_WIDTH:0] push_word;

  assign accept    = (state == S_IDLE) && ap_start;
  // Everything already committed: reads in flight, words queued, and the head register
  assign occupancy = LP_OCC_W'($countones(rd_pipe)) + LP_OCC_W'(mem_cnt) + LP_OCC_W'(m_axis_tvalid);
  assign issue     = ((state == S_START) || (state == S_STREAM)) && (rd_cnt != len) &&
                     (occupancy < LP_OCC_W'(C_FIFO_DEPTH));
  assign push      = rd_pipe[C_BUF_RD_LATENCY-1];
  assign push_last = (ret_cnt == (len - 12'd1));
  assign push_word = {push_last, rd_data};
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  // An empty queue lets returning data bypass straight into the head register
  assign load_mem  = out_free && (mem_cnt != LP_CNT_W'(0));
  assign load_in   = out_free && (mem_cnt == LP_CNT_W'(0)) && push;
  assign mem_push  = push && !load_in;

  assign save_read_buffer_0_valid   = issue && group[0];
  assign save_read_buffer_1_A_valid = issue && group[1];
  assign save_read_buffer_1_B_valid = issue && group[2];
  assign save_read_buffer_2_A_valid = issue && group[3];
  assign save_read_buffer_2_B_valid = issue && group[4];
  assign save_read_buffer_0_addr    = rd_addr;
  assign save_read_buffer_1_A_addr  = rd_addr;
  assign save_read_buffer_1_B_addr  = rd_addr;
  assign save_read_buffer_2_A_addr  = rd_addr;
  assign save_read_buffer_2_B_addr  = rd_addr;
  assign wr_ctrl_start = (state == S_START);
  assign ap_done       = (state == S_FIN);

  // Select the returning read data of the active buffer
  always_comb begin
    rd_data = '0;
    case (group)
      5'b00001: rd_data = save_read_buffer_0_data;
      5'b00010: rd_data = save_read_buffer_1_A_data;
      5'b00100: rd_data = save_read_buffer_1_B_data;
      5'b01000: rd_data = save_read_buffer_2_A_data;
      5'b10000: rd_data = save_read_buffer_2_B_data;
      default:  rd_data = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          if ((inst_len == 12'd0) || !inst_group_ok) state_next = S_FIN;
          else                                        state_next = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_START: state_next = S_STREAM;
      S_STREAM: begin
        if (pop && m_axis_tlast) begin
          if (done_seen || wr_ctrl_done) state_next = S_FIN;
          else                           state_next = S_WAIT;
        end else begin
          state_next = S_STREAM;
        end
      end
      S_WAIT: begin
        if (done_seen || wr_ctrl_done) state_next = S_FIN;
        else                           state_next = S_WAIT;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) state <= S_IDLE;
    else            state <= state_next;
  end

  // Instruction latch, read sequencing, read-latency tracking, sticky done
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      group                      <= 5'd0;
      len                        <= 12'd0;
      rd_addr                    <= 11'd0;
      rd_cnt                     <= 12'd0;
      ret_cnt                    <= 12'd0;
      done_seen                  <= 1'b0;
      rd_pipe                    <= '0;
      wr_ctrl_addr_offset        <= '0;
      wr_ctrl_xfer_size_in_bytes <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | C_BUF_RD_LATENCY'(issue);
      if (accept) begin
        group                      <= inst_group[4:0];
        len                        <= inst_len;
        rd_addr                    <= inst_buf_start;
        rd_cnt                     <= 12'd0;
        ret_cnt                    <= 12'd0;
        wr_ctrl_addr_offset        <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(inst_dram);
        wr_ctrl_xfer_size_in_bytes <= C_XFER_SIZE_WIDTH'(inst_len) * C_XFER_SIZE_WIDTH'(LP_DW_BYTES);
      end else begin
        if (issue) begin
          rd_addr <= rd_addr + 11'd1;
          rd_cnt  <= rd_cnt + 12'd1;
        end
        if (push) ret_cnt <= ret_cnt + 12'd1;
      end
      if (state == S_IDLE)   done_seen <= 1'b0;
      else if (wr_ctrl_done) done_seen <= 1'b1;
      else                   done_seen <= done_seen;
    end
  end

  // FIFO storage write (no reset needed: occupancy tracking gates every read)
  always_ff @(posedge kernel_clk) begin
    if (mem_push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, count, and registered stream head
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (mem_push) wr_ptr <= (wr_ptr == LP_PTR_W'(C_FIFO_DEPTH - 1)) ? '0 : wr_ptr + LP_PTR_W'(1);
      if (load_mem) rd_ptr <= (rd_ptr == LP_PTR_W'(C_FIFO_DEPTH - 1)) ? '0 : rd_ptr + LP_PTR_W'(1);
      case ({mem_push, load_mem})
        2'b10:   mem_cnt <= mem_cnt + LP_CNT_W'(1);
        2'b01:   mem_cnt <= mem_cnt - LP_CNT_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (load_mem) begin
        {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
        m_axis_tvalid                <= 1'b1;
      end else if (load_in) begin
        {m_axis_tlast, m_axis_tdata} <= push_word;
        m_axis_tvalid                <= 1'b1;
      end else if (pop) begin
        m_axis_tvalid <= 1'b0;
      end else begin
        m_axis_tvalid <= m_axis_tvalid;
      end
    end
  end

endmodule

// File: tb/tb_save_store.sv
// Testbench for save_store: buffer models with 2-cycle read latency, a
// negedge monitor recording reads/beats/pulses, and per-scenario tasks that
// compare against a spec-level model of the transfer.
module tb_save_store;
  localparam int DW = 512, AW = 64, IW = 128, XW = 32;

  logic kernel_clk = 1'b0, kernel_rst = 1'b0;
  logic ap_start = 1'b0, ap_done;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [IW-1:0] ctrl_instruction = '0;
  logic v0, v1a, v1b, v2a, v2b;
  logic [10:0] a0, a1a, a1b, a2a, a2b;
  logic [DW-1:0] bd [5];
  logic wr_ctrl_start, wr_ctrl_done = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [XW-1:0] wr_size;
  logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;

  save_store dut (
    .kernel_clk(kernel_clk), .kernel_rst(kernel_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .save_read_buffer_0_valid(v0),   .save_read_buffer_0_addr(a0),   .save_read_buffer_0_data(bd[0]),
    .save_read_buffer_1_A_valid(v1a), .save_read_buffer_1_A_addr(a1a), .save_read_buffer_1_A_data(bd[1]),
    .save_read_buffer_1_B_valid(v1b), .save_read_buffer_1_B_addr(a1b), .save_read_buffer_1_B_data(bd[2]),
    .save_read_buffer_2_A_valid(v2a), .save_read_buffer_2_A_addr(a2a), .save_read_buffer_2_A_data(bd[3]),
    .save_read_buffer_2_B_valid(v2b), .save_read_buffer_2_B_addr(a2b), .save_read_buffer_2_B_data(bd[4]),
    .wr_ctrl_start(wr_ctrl_start), .wr_ctrl_addr_offset(wr_addr), .wr_ctrl_xfer_size_in_bytes(wr_size),
    .wr_ctrl_done(wr_ctrl_done), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 kernel_clk = ~kernel_clk;

  int tests_run = 0, tests_failed = 0, cyc = 0;
  logic [4:0] rv;
  logic [10:0] ra [5];
  assign rv = {v2b, v2a, v1b, v1a, v0};
  assign ra[0] = a0; assign ra[1] = a1a; assign ra[2] = a1b; assign ra[3] = a2a; assign ra[4] = a2b;

  logic [AW+XW+DW+63:0] outs;
  assign outs = {ap_done, wr_ctrl_start, m_axis_tvalid, m_axis_tlast, rv, a0, a1a, a1b, a2a, a2b,
                 wr_addr, wr_size, m_axis_tdata};

  // Buffer contents: a word is a pure function of buffer index, address and a per-run salt
  logic [31:0] salt = 32'h1234_5678;
  function automatic logic [DW-1:0] word(input int b, input logic [10:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = salt ^ (32'(b) << 28) ^ (32'(a) << 8) ^ 32'(i);
    return w;
  endfunction

  // Read pipelines: request in cycle c, data presented in cycle c+2
  logic [11:0] bp1 [5], bp2 [5];
  always @(posedge kernel_clk) begin
    for (int b = 0; b < 5; b++) begin
      bp1[b] <= {rv[b], ra[b]};
      bp2[b] <= bp1[b];
    end
  end
  always_comb begin
    for (int b = 0; b < 5; b++) bd[b] = bp2[b][11] ? word(b, bp2[b][10:0]) : {16{32'hDEADBEEF}};
  end

  // Monitor state
  int rd_q[$], rdc_q[$], beatc_q[$], done_q[$], start_q[$], wrdone_q[$];
  logic [DW:0] beat_q[$];
  int issued, popped, max_out, stall_err, out_now;
  logic stall_prev;
  logic [DW:0] hold;

  initial forever begin
    @(posedge kernel_clk);
    cyc++;
  end

  // Mid-cycle observation of all DUT activity
  initial forever begin
    @(negedge kernel_clk);
    if (kernel_rst) begin
      stall_prev = 1'b0;
    end else begin
      for (int b = 0; b < 5; b++) if (rv[b]) begin
        rd_q.push_back(b * 4096 + int'(ra[b]));
        rdc_q.push_back(cyc);
        issued++;
      end
      out_now = issued - popped;
      if (out_now > max_out) max_out = out_now;
      if (stall_prev && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} !== hold))) stall_err++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        beat_q.push_back({m_axis_tlast, m_axis_tdata});
        beatc_q.push_back(cyc);
        popped++;
      end
      if (ap_done) done_q.push_back(cyc);
      if (wr_ctrl_start) start_q.push_back(cyc);
      if (wr_ctrl_done) wrdone_q.push_back(cyc);
    end
  end

  task automatic clear_obs();
    rd_q.delete(); rdc_q.delete(); beat_q.delete(); beatc_q.delete();
    done_q.delete(); start_q.delete(); wrdone_q.delete();
    issued = 0; popped = 0; max_out = 0; stall_err = 0; stall_prev = 1'b0;
  endtask

  // Instruction builder: unused bits are randomised to exercise field decoding
  function automatic logic [IW-1:0] mk_inst(input logic [5:0] g, input int start, input int len, input int dram);
    logic [IW-1:0] i;
    i = {$urandom(), $urandom(), $urandom(), $urandom()};
    i[5:0] = g; i[42:32] = 11'(start); i[59:48] = 12'(len); i[79:64] = 16'(dram);
    return i;
  endfunction

  // Model: mismatches between observed beats and the spec's expected stream
  function automatic int beat_errors(input int b, input int start, input int len);
    int e;
    logic [DW:0] ex;
    e = (beat_q.size() != len) ? 1 : 0;
    for (int i = 0; i < beat_q.size() && i < len; i++) begin
      ex = {(i == len - 1), word(b, 11'((start + i) % 2048))};
      if (beat_q[i] !== ex) e++;
    end
    return e;
  endfunction

  // Model: mismatches between observed reads and the expected buffer/address sequence
  function automatic int read_errors(input int b, input int start, input int len);
    int e;
    e = (rd_q.size() != len) ? 1 : 0;
    for (int i = 0; i < rd_q.size() && i < len; i++)
      if (rd_q[i] != b * 4096 + ((start + i) % 2048)) e++;
    return e;
  endfunction

  function automatic int exp_done_cycle();
    int h, d;
    h = (beatc_q.size() > 0) ? beatc_q[beatc_q.size()-1] : 0;
    d = (wrdone_q.size() > 0) ? wrdone_q[0] : 0;
    return ((h > d) ? h : d) + 1;
  endfunction

  // Drive one instruction; done_beat>=0 pulses wr_ctrl_done once that many beats
  // have been seen, otherwise it pulses done_delay cycles after the tlast beat.
  task automatic run_xfer(input logic [IW-1:0] inst, input logic [AW-1:0] off, input int tmode,
                          input int done_beat, input int done_delay, input int budget, output int c0);
    int n;
    bit pulsed;
    clear_obs();
    salt = $urandom();
    @(posedge kernel_clk); #1;
    ctrl_instruction = inst; ctrl_addr_offset = off; ap_start = 1'b1; c0 = cyc;
    m_axis_tready = (tmode == 0) ? 1'b1 : ((cyc % 3) == 0);
    @(posedge kernel_clk); #1;
    ap_start = 1'b0; pulsed = 0; n = 0;
    while (done_q.size() == 0 && n < budget) begin
      m_axis_tready = (tmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      wr_ctrl_done = 1'b0;
      if (!pulsed) begin
        if (done_beat >= 0 && beat_q.size() >= done_beat) begin
          wr_ctrl_done = 1'b1; pulsed = 1;
        end else if (done_beat < 0 && beat_q.size() > 0 && beat_q[beat_q.size()-1][DW] &&
                     cyc >= beatc_q[beatc_q.size()-1] + done_delay) begin
          wr_ctrl_done = 1'b1; pulsed = 1;
        end
      end
      @(posedge kernel_clk); #1;
      n++;
    end
    wr_ctrl_done = 1'b0; m_axis_tready = 1'b1;
    tests_run++;
    if (done_q.size() == 0) begin
      tests_failed++;
      $display("FAIL xfer_timeout: no ap_done after %0d cycles, required ap_done", budget);
    end
    repeat (4) @(posedge kernel_clk);
    #1;
  endtask

  task automatic test_reset();
    kernel_rst = 1'b1;
    #2;
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h, required 0", outs); end
    repeat (3) @(posedge kernel_clk);
    #1 kernel_rst = 1'b0;
    @(posedge kernel_clk); #1;
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL post_reset_outputs: got %h, required 0", outs); end
  endtask

  task automatic test_basic();
    int c0, e;
    run_xfer(mk_inst(6'd1, 5, 4, 32'h40), 64'h1000, 0, -1, 3, 200, c0);
    tests_run++;
    e = read_errors(0, 5, 4);
    for (int i = 0; i < rdc_q.size(); i++) if (rdc_q[i] != c0 + 1 + i) e++;
    if (e != 0) begin tests_failed++; $display("FAIL basic_reads: %0d bad reads, required 0", e); end
    tests_run++;
    if (wr_addr !== 64'h1040) begin tests_failed++; $display("FAIL basic_addr: got %h, required 1040", wr_addr); end
    tests_run++;
    if (wr_size !== 32'd256) begin tests_failed++; $display("FAIL basic_size: got %0d, required 256", wr_size); end
    tests_run++;
    e = beat_errors(0, 5, 4);
    if (e != 0) begin tests_failed++; $display("FAIL basic_beats: %0d bad beats, required 0", e); end
    tests_run++;
    if (start_q.size() != 1 || start_q[0] != c0 + 1) begin
      tests_failed++; $display("FAIL basic_start: %0d pulses, required 1 at cycle %0d", start_q.size(), c0 + 1);
    end
    tests_run++;
    if (beatc_q.size() != 4 || beatc_q[0] != c0 + 4 || beatc_q[3] != c0 + 7) begin
      tests_failed++; $display("FAIL basic_beat_timing: %0d beats, required 4 in cycles %0d..%0d", beatc_q.size(), c0 + 4, c0 + 7);
    end
    tests_run++;
    if (done_q.size() != 1 || done_q[0] != exp_done_cycle()) begin
      tests_failed++; $display("FAIL basic_done: %0d pulses, required 1 at cycle %0d", done_q.size(), exp_done_cycle());
    end
  endtask

  task automatic test_wrap();
    int c0, e;
    run_xfer(mk_inst(6'h08, 2046, 4, 0), 64'h0, 0, -1, 1, 200, c0);
    tests_run++;
    e = read_errors(3, 2046, 4);
    if (e != 0) begin tests_failed++; $display("FAIL wrap_reads: %0d bad reads, required 0", e); end
    tests_run++;
    e = beat_errors(3, 2046, 4);
    if (e != 0) begin tests_failed++; $display("FAIL wrap_beats: %0d bad beats, required 0", e); end
  endtask

  task automatic test_backpressure();
    int c0, e, b, st;
    b = $urandom_range(4, 0); st = $urandom_range(2047, 0);
    run_xfer(mk_inst(6'(1 << b), st, 32, $urandom_range(65535, 0)), {$urandom(), $urandom()}, 1, -1, 2, 600, c0);
    tests_run++;
    if (max_out > 8) begin tests_failed++; $display("FAIL bp_credit: outstanding %0d, required <= 8", max_out); end
    tests_run++;
    if (stall_err != 0) begin tests_failed++; $display("FAIL bp_stable: %0d changes while stalled, required 0", stall_err); end
    tests_run++;
    e = beat_errors(b, st, 32) + read_errors(b, st, 32);
    if (e != 0) begin tests_failed++; $display("FAIL bp_data: %0d errors, required 0", e); end
    tests_run++;
    if (done_q.size() != 1) begin tests_failed++; $display("FAIL bp_done: %0d pulses, required 1", done_q.size()); end
  endtask

  task automatic test_degenerate();
    int c0;
    logic [5:0] gs [2];
    int ls [2];
    gs[0] = 6'd1; ls[0] = 0;
    gs[1] = 6'h03; ls[1] = 5;
    for (int k = 0; k < 2; k++) begin
      run_xfer(mk_inst(gs[k], 10, ls[k], 0), 64'h0, 0, -1, 1, 50, c0);
      tests_run++;
      if (done_q.size() != 1 || done_q[0] != c0 + 1) begin
        tests_failed++; $display("FAIL degen_done_%0d: %0d pulses, required 1 at cycle %0d", k, done_q.size(), c0 + 1);
      end
      tests_run++;
      if (start_q.size() != 0 || issued != 0 || popped != 0) begin
        tests_failed++; $display("FAIL degen_quiet_%0d: starts %0d reads %0d beats %0d, required 0", k, start_q.size(), issued, popped);
      end
    end
  endtask

  task automatic test_early_done();
    int c0, e;
    run_xfer(mk_inst(6'h10, 100, 8, 7), 64'h20, 0, 2, 0, 200, c0);
    tests_run++;
    e = beat_errors(4, 100, 8);
    if (e != 0) begin tests_failed++; $display("FAIL early_beats: %0d bad beats, required 0", e); end
    tests_run++;
    if (done_q.size() != 1 || beatc_q.size() != 8 || done_q[0] != beatc_q[7] + 1) begin
      tests_failed++; $display("FAIL early_done: %0d pulses, required 1 right after beat 8", done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int c0, e, n, st;
    clear_obs();
    @(posedge kernel_clk); #1;
    ctrl_instruction = mk_inst(6'd2, 300, 16, 0); ap_start = 1'b1;
    @(posedge kernel_clk); #1;
    ap_start = 1'b0; n = 0;
    while (beat_q.size() < 3 && n < 100) begin @(posedge kernel_clk); #1; n++; end
    #2 kernel_rst = 1'b1;
    #1;
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL midreset_outputs: got %h, required 0", outs); end
    repeat (3) @(posedge kernel_clk);
    #1;
    tests_run++;
    if (done_q.size() != 0 || beat_q.size() != 3) begin
      tests_failed++; $display("FAIL midreset_abort: done %0d beats %0d, required 0 and 3", done_q.size(), beat_q.size());
    end
    kernel_rst = 1'b0;
    st = $urandom_range(2047, 0);
    run_xfer(mk_inst(6'd2, st, 6, 0), 64'h0, 0, -1, 1, 200, c0);
    tests_run++;
    e = beat_errors(1, st, 6) + read_errors(1, st, 6);
    if (e != 0 || done_q.size() != 1) begin
      tests_failed++; $display("FAIL midreset_rerun: %0d errors %0d done, required 0 and 1", e, done_q.size());
    end
  endtask

  task automatic test_random();
    int c0, e, b, st, ln, tm;
    logic [AW-1:0] off;
    for (int k = 0; k < 4; k++) begin
      b = $urandom_range(4, 0); st = $urandom_range(2047, 0);
      ln = (k == 3) ? 3000 : $urandom_range(40, 1);
      tm = (k == 3) ? 0 : $urandom_range(1, 0);
      off = {$urandom(), $urandom()};
      run_xfer(mk_inst(6'(1 << b), st, ln, 16'hFFF0 + k), off, tm, -1, $urandom_range(4, 0), 6000, c0);
      if (ln > 2048) ln = 2048;
      tests_run++;
      e = beat_errors(b, st, ln) + read_errors(b, st, ln);
      if (e != 0) begin tests_failed++; $display("FAIL rand_%0d_data: %0d errors, required 0", k, e); end
      tests_run++;
      if (wr_addr !== off + 64'(16'hFFF0 + k) || wr_size !== 32'(ln * 64)) begin
        tests_failed++; $display("FAIL rand_%0d_ctrl: addr %h size %0d, required %h %0d", k, wr_addr, wr_size, off + 64'(16'hFFF0 + k), ln * 64);
      end
      tests_run++;
      if (done_q.size() != 1 || done_q[0] != exp_done_cycle()) begin
        tests_failed++; $display("FAIL rand_%0d_done: %0d pulses, required 1 at %0d", k, done_q.size(), exp_done_cycle());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_degenerate();
    test_early_done();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
